// File: rtl/lvdc_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : lvdc_bit_timer
// Description : Bench timing generator: one-hot bit phases, bit/syllable
//               counters, word strobe and mid-bit flip-flop clock strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module lvdc_bit_timer #(
    parameter int PHASES    = 4,
    parameter int BITS      = 14,
    parameter int CLK_PHASE = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     step,
    output logic [PHASES-1:0]        phase,
    output logic [$clog2(BITS)-1:0]  bit_idx,
    output logic                     syllable,
    output logic                     word_strobe,
    output logic                     ff_clk,
    output logic                     running
);

    localparam int c_bit_w = $clog2(BITS);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_run   = 2'd1;
    localparam logic [1:0] c_drain = 2'd2;

    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(BITS - 1);
    localparam logic [PHASES-1:0]  c_first_ph = {{(PHASES-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic [PHASES-1:0]  r_phase;
    logic [c_bit_w-1:0] r_bit_idx;
    logic               r_syllable;
    logic               r_word_strobe;
    logic               r_ff_clk;
    logic               r_running;

    logic [1:0]         w_state_nxt;
    logic [PHASES-1:0]  w_phase_nxt;
    logic [c_bit_w-1:0] w_bit_nxt;
    logic               w_syl_nxt;
    logic               w_ws_nxt;
    logic               w_last_ph;

    assign w_last_ph = r_phase[PHASES-1];

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_bit_nxt   = r_bit_idx;
        w_syl_nxt   = r_syllable;
        w_ws_nxt    = 1'b0;
        case (r_state)
            c_idle: begin
                if (run) begin
                    w_state_nxt = c_run;
                    w_phase_nxt = c_first_ph;
                end else if (step) begin
                    w_state_nxt = c_drain;
                    w_phase_nxt = c_first_ph;
                end
            end
            c_run, c_drain: begin
                // RUN and DRAIN differ only in how the run level is sampled
                if (w_last_ph) begin
                    if (r_bit_idx == c_last_bit) begin
                        w_bit_nxt = '0;
                        w_syl_nxt = ~r_syllable;
                        w_ws_nxt  = r_syllable;
                    end else begin
                        w_bit_nxt = r_bit_idx + c_bit_w'(1);
                    end
                    if (run) begin
                        w_state_nxt = c_run;
                        w_phase_nxt = c_first_ph;
                    end else begin
                        w_state_nxt = c_idle;
                        w_phase_nxt = '0;
                    end
                end else begin
                    w_phase_nxt = {r_phase[PHASES-2:0], 1'b0};
                    w_state_nxt = run ? c_run : c_drain;
                end
            end
            default: begin
                w_state_nxt = c_idle;
                w_phase_nxt = '0;
            end
        endcase
    end

    // ff_clk and running are registered from next-state values so they
    // line up with phase without any combinational path from inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_idle;
            r_phase       <= '0;
            r_bit_idx     <= '0;
            r_syllable    <= 1'b0;
            r_word_strobe <= 1'b0;
            r_ff_clk      <= 1'b0;
            r_running     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_phase       <= w_phase_nxt;
            r_bit_idx     <= w_bit_nxt;
            r_syllable    <= w_syl_nxt;
            r_word_strobe <= w_ws_nxt;
            r_ff_clk      <= w_phase_nxt[CLK_PHASE];
            r_running     <= (w_state_nxt != c_idle);
        end
    end

    assign phase       = r_phase;
    assign bit_idx     = r_bit_idx;
    assign syllable    = r_syllable;
    assign word_strobe = r_word_strobe;
    assign ff_clk      = r_ff_clk;
    assign running     = r_running;

endmodule
`default_nettype wire
